// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator host link: operator encodings, the
// ASCII characters used by the calculator terminal protocol, command and
// response line lengths, error codes, FSM state type and the operator to
// keystroke mapping.
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int CMD_LEN = 15;  // op, 6 digits, '.', 6 digits, CR
  localparam int RSP_LEN = 20;  // CR LF, sign/NaN, digits, '.', digits, " >> "

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_SIN = 3'd4;
  localparam logic [2:0] OP_COS = 3'd5;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] DOT   = 8'h2E;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] GT    = 8'h3E;
  localparam logic [7:0] STAR  = 8'h2A;
  localparam logic [7:0] SLASH = 8'h2F;
  localparam logic [7:0] CH_S  = 8'h73;
  localparam logic [7:0] CH_C  = 8'h63;
  localparam logic [7:0] CH_UN = 8'h4E;  // 'N'
  localparam logic [7:0] CH_LA = 8'h61;  // 'a'
  localparam logic [7:0] ZERO  = 8'h30;

  localparam logic [47:0] DIGITS_ZERO = {6{ZERO}};

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ECHO    = 2'b10;
  localparam logic [1:0] ERR_FRAME   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT_ECHO,
    ST_COLLECT,
    ST_DONE
  } state_e;

  // Operator code to keystroke; unused codes fall back to '+'.
  function automatic logic [7:0] op_char(input logic [2:0] op);
    logic [7:0] c;
    c = PLUS;
    case (op)
      OP_ADD:  c = PLUS;
      OP_SUB:  c = MINUS;
      OP_MUL:  c = STAR;
      OP_DIV:  c = SLASH;
      OP_SIN:  c = CH_S;
      OP_COS:  c = CH_C;
      default: c = PLUS;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/calc_rsp_parser.sv
// -----------------------------------------------------------------------------
// calc_rsp_parser
// Combinational decode of one 20-byte calculator result line into fields.
// Byte 0 of the line sits in the most significant byte of line_i.
//   line_i      : 160-bit result line
//   neg_o       : sign character was '-'
//   nan_o       : line carries "NaN"
//   bfd_o/afd_o : ASCII digits before/after the point (all '0' for NaN)
//   frame_err_o : CR LF header, " >> " trailer or '.' position is wrong
// -----------------------------------------------------------------------------
module calc_rsp_parser
  import calc_pkg::*;
(
  input  logic [8*RSP_LEN-1:0] line_i,
  output logic                 neg_o,
  output logic                 nan_o,
  output logic [47:0]          bfd_o,
  output logic [47:0]          afd_o,
  output logic                 frame_err_o
);

  logic [7:0] byte_w [RSP_LEN];

  generate
    for (genvar gi = 0; gi < RSP_LEN; gi++) begin : g_bytes
      assign byte_w[gi] = line_i[8*(RSP_LEN-1-gi) +: 8];
    end
  endgenerate

  logic frame_ok;
  logic is_nan;
  logic dot_ok;

  assign frame_ok = (byte_w[0] == CR) && (byte_w[1] == LF) &&
                    (byte_w[16] == SPACE) && (byte_w[17] == GT) &&
                    (byte_w[18] == GT) && (byte_w[19] == SPACE);
  assign is_nan   = (byte_w[2] == CH_UN) && (byte_w[3] == CH_LA) && (byte_w[4] == CH_UN);
  assign dot_ok   = (byte_w[9] == DOT);

  assign nan_o       = is_nan;
  assign neg_o       = !is_nan && (byte_w[2] == MINUS);
  assign bfd_o       = is_nan ? DIGITS_ZERO
                              : {byte_w[3], byte_w[4], byte_w[5], byte_w[6], byte_w[7], byte_w[8]};
  assign afd_o       = is_nan ? DIGITS_ZERO
                              : {byte_w[10], byte_w[11], byte_w[12], byte_w[13], byte_w[14], byte_w[15]};
  // A NaN line has no decimal point, so only numeric lines need byte 9 = '.'.
  assign frame_err_o = !frame_ok || (!is_nan && !dot_ok);

endmodule

// File: rtl/calc_host_link.sv
// -----------------------------------------------------------------------------
// calc_host_link
// Host-side initiator for the UART calculator terminal. Sends one command as
// 15 keystrokes, lock-stepping each against the calculator echo, then collects
// the 20-byte result line and presents it as parallel fields.
//
// Ports:
//   clk, reset_n          baud tick clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only when idle)
//   cmd_op, cmd_bfd/afd   operator code and ASCII operand digits
//   tx_data, tx_wr_en     byte and one-cycle strobe towards uart_tx
//   tx_sent               uart_tx ready level
//   rx_data, rx_received  byte and byte-complete level from uart_rx
//   rsp_valid             one-cycle result strobe
//   rsp_neg, rsp_nan, rsp_bfd, rsp_afd, rsp_err   result fields
//
// Build option: define CALC_ECHO_CHECK_EN to compare each echo with the byte
// sent; otherwise only the arrival of an echo is awaited.
// -----------------------------------------------------------------------------
module calc_host_link
  import calc_pkg::*;
#(
  parameter int GAP_CYCLES     = 20,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [47:0] cmd_bfd,
  input  logic [47:0] cmd_afd,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  input  logic        tx_sent,
  input  logic [7:0]  rx_data,
  input  logic        rx_received,
  output logic        rsp_valid,
  output logic        rsp_neg,
  output logic [47:0] rsp_bfd,
  output logic [47:0] rsp_afd,
  output logic        rsp_nan,
  output logic [1:0]  rsp_err
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_e                   state_q;
  logic [8*CMD_LEN-1:0]     tx_buf_q;
  logic [3:0]               tx_cnt_q;
  logic [GAP_W-1:0]         gap_cnt_q;
  logic [TO_W-1:0]          to_cnt_q;
  // Only the first 19 bytes are stored; the 20th is used straight from rx_data.
  logic [8*(RSP_LEN-1)-1:0] rx_buf_q;
  logic [4:0]               rx_cnt_q;
  logic                     rx_prev_q;
  logic                     err_echo_q;
  logic [7:0]               tx_data_q;
  logic                     tx_wr_en_q;
  logic                     rsp_valid_q;
  logic                     rsp_neg_q;
  logic                     rsp_nan_q;
  logic [47:0]              rsp_bfd_q;
  logic [47:0]              rsp_afd_q;
  logic [1:0]               rsp_err_q;

  logic                 rx_new;
  logic [8*RSP_LEN-1:0] rx_line_d;
  logic                 waiting_rx;
  logic                 timeout_d;
  logic                 last_rx_d;
  logic                 finish_d;

  logic        p_neg;
  logic        p_nan;
  logic [47:0] p_bfd;
  logic [47:0] p_afd;
  logic        p_frame_err;

  logic [1:0]  err_d;
  logic        neg_d;
  logic        nan_d;
  logic [47:0] bfd_d;
  logic [47:0] afd_d;

  assign rx_new     = rx_received & ~rx_prev_q;
  assign rx_line_d  = {rx_buf_q, rx_data};
  assign waiting_rx = (state_q == ST_WAIT_ECHO) || (state_q == ST_COLLECT);
  assign timeout_d  = waiting_rx && !rx_new && (to_cnt_q == TO_LAST);
  assign last_rx_d  = (state_q == ST_COLLECT) && rx_new && (rx_cnt_q == 5'(RSP_LEN - 1));
  assign finish_d   = timeout_d || last_rx_d;

  calc_rsp_parser u_parser (
    .line_i      (rx_line_d),
    .neg_o       (p_neg),
    .nan_o       (p_nan),
    .bfd_o       (p_bfd),
    .afd_o       (p_afd),
    .frame_err_o (p_frame_err)
  );

  // Result fields as they will be latched on entry to DONE. Any error
  // invalidates the fields.
  always_comb begin
    err_d = ERR_OK;
    neg_d = 1'b0;
    nan_d = 1'b0;
    bfd_d = DIGITS_ZERO;
    afd_d = DIGITS_ZERO;
    if (timeout_d) begin
      err_d = ERR_TIMEOUT;
    end else if (err_echo_q) begin
      err_d = ERR_ECHO;
    end else if (p_frame_err) begin
      err_d = ERR_FRAME;
    end else begin
      neg_d = p_neg;
      nan_d = p_nan;
      bfd_d = p_bfd;
      afd_d = p_afd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tx_buf_q    <= '0;
      tx_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
      rx_buf_q    <= '0;
      rx_cnt_q    <= '0;
      rx_prev_q   <= 1'b0;
      err_echo_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_wr_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_nan_q   <= 1'b0;
      rsp_bfd_q   <= '0;
      rsp_afd_q   <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      // Tracked in every state so bytes arriving while idle are swallowed.
      rx_prev_q   <= rx_received;
      tx_wr_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            tx_buf_q   <= {op_char(cmd_op), cmd_bfd, DOT, cmd_afd, CR};
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            err_echo_q <= 1'b0;
            state_q    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (rx_new) err_echo_q <= 1'b1;
          if (tx_sent) begin
            tx_data_q  <= tx_buf_q[8*CMD_LEN-1 -: 8];
            tx_wr_en_q <= 1'b1;
            tx_buf_q   <= {tx_buf_q[8*CMD_LEN-9:0], 8'h00};
            tx_cnt_q   <= tx_cnt_q + 4'd1;
            gap_cnt_q  <= '0;
            state_q    <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (rx_new) err_echo_q <= 1'b1;
          if (gap_cnt_q == GAP_LAST) begin
            to_cnt_q <= '0;
            // The CR is not echoed on its own; the response line starts instead.
            state_q  <= (tx_cnt_q == 4'(CMD_LEN)) ? ST_COLLECT : ST_WAIT_ECHO;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end

        ST_WAIT_ECHO: begin
          if (rx_new) begin
`ifdef CALC_ECHO_CHECK_EN
            if (rx_data != tx_data_q) err_echo_q <= 1'b1;
`endif
            state_q <= ST_SEND;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        ST_COLLECT: begin
          if (rx_new) begin
            rx_buf_q <= rx_line_d[8*(RSP_LEN-1)-1:0];
            rx_cnt_q <= rx_cnt_q + 5'd1;
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase

      // Timeout or final response byte: latch the result and strobe it while
      // the FSM sits in DONE.
      if (finish_d) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err_d;
        rsp_neg_q   <= neg_d;
        rsp_nan_q   <= nan_d;
        rsp_bfd_q   <= bfd_d;
        rsp_afd_q   <= afd_d;
        state_q     <= ST_DONE;
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign tx_data   = tx_data_q;
  assign tx_wr_en  = tx_wr_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_nan   = rsp_nan_q;
  assign rsp_bfd   = rsp_bfd_q;
  assign rsp_afd   = rsp_afd_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_calc_host_link.sv
// -----------------------------------------------------------------------------
// tb_calc_host_link
// Directed bench for calc_host_link with a small UART/calculator responder.
// -----------------------------------------------------------------------------
module tb_calc_host_link;

  localparam int GAP = 20;
  localparam int TMO = 4096;

`ifdef CALC_ECHO_CHECK_EN
  localparam logic [1:0] ECHO_EXP_ERR = 2'b10;
`else
  localparam logic [1:0] ECHO_EXP_ERR = 2'b00;
`endif

  localparam logic [119:0] EXP_SEQ1  = 120'h2B_30_30_30_30_31_32_2E_35_30_30_30_30_30_0D;
  localparam logic [159:0] LINE_OK   = {"\r\n", "+000012.500000", " >> "};
  localparam logic [159:0] LINE_NAN  = {16'h0D0A, 24'h4E614E, {12{8'h20}}, 24'h3E3E20};
  localparam logic [159:0] LINE_BADT = {"\r\n", "+000012.500000", " >>X"};
  localparam logic [159:0] LINE_NEG  = {"\r\n", "-000003.000000", " >> "};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [47:0] cmd_bfd;
  logic [47:0] cmd_afd;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        tx_sent;
  logic [7:0]  rx_data;
  logic        rx_received;
  logic        rsp_valid;
  logic        rsp_neg;
  logic [47:0] rsp_bfd;
  logic [47:0] rsp_afd;
  logic        rsp_nan;
  logic [1:0]  rsp_err;

  always #5 clk = ~clk;

  calc_host_link #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_bfd     (cmd_bfd),
    .cmd_afd     (cmd_afd),
    .tx_data     (tx_data),
    .tx_wr_en    (tx_wr_en),
    .tx_sent     (tx_sent),
    .rx_data     (rx_data),
    .rx_received (rx_received),
    .rsp_valid   (rsp_valid),
    .rsp_neg     (rsp_neg),
    .rsp_bfd     (rsp_bfd),
    .rsp_afd     (rsp_afd),
    .rsp_nan     (rsp_nan),
    .rsp_err     (rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tx_n    = 0;
  int rsp_n   = 0;
  int wr_cyc  = 0;
  int rsp_cyc = 0;
  int tx_base = 0;
  int rsp_base = 0;
  logic [7:0] tx_log [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  // Transmit and result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_wr_en) begin
      tx_log[tx_n[7:0]] <= tx_data;
      tx_n   <= tx_n + 1;
      wr_cyc <= cyc;
    end
    if (rsp_valid) begin
      rsp_n   <= rsp_n + 1;
      rsp_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [119:0] tx_seq(input int base);
    logic [119:0] v;
    v = '0;
    for (int i = 0; i < 15; i++) v = {v[111:0], tx_log[(base + i) % 256]};
    return v;
  endfunction

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    rx_received = 1'b1;
    @(negedge clk);
    rx_received = 1'b0;
  endtask

  task automatic wait_tx(input int target, output bit ok);
    int t;
    t = 0;
    while (tx_n < target && t < 3000) begin
      @(posedge clk);
      t++;
    end
    ok = (tx_n >= target);
  endtask

  // mode 0: echo every byte; 1: never echo; 2: echo 0x39 in place of 0x31.
  task automatic responder(input int base, input int mode, input logic [159:0] line);
    bit ok;
    logic [7:0] eb;
    for (int i = 0; i < 15; i++) begin
      wait_tx(base + i + 1, ok);
      if (!ok) return;
      if (mode == 1) return;
      repeat (GAP + 2) @(negedge clk);
      if (i < 14) begin
        eb = tx_log[(base + i) % 256];
        if (mode == 2 && eb == 8'h31) eb = 8'h39;
        send_rx(eb);
      end
    end
    for (int k = 0; k < 20; k++) begin
      send_rx(line[159 - 8*k -: 8]);
      @(negedge clk);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [47:0] bfd, input logic [47:0] afd,
                         input int mode, input logic [159:0] line, input bit hold);
    int t;
    tx_base  = tx_n;
    rsp_base = rsp_n;
    fork
      responder(tx_base, mode, line);
      begin
        @(negedge clk);
        cmd_op    = op;
        cmd_bfd   = bfd;
        cmd_afd   = afd;
        cmd_valid = 1'b1;
        if (hold) tx_sent = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (hold) begin
          repeat (10) @(negedge clk);
          check("send_waits_tx_sent", tx_n - tx_base, 0);
          tx_sent = 1'b1;
        end
        t = 0;
        while (rsp_n == rsp_base && t < 20000) begin
          @(posedge clk);
          t++;
        end
        #1;
        check("ready_after_rsp", cmd_ready, 1'b1);
      end
    join
    repeat (5) @(negedge clk);
    check("rsp_valid_once", rsp_n - rsp_base, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_bfd     = '0;
    cmd_afd     = '0;
    tx_sent     = 1'b1;
    rx_data     = '0;
    rx_received = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_tx_wr_en", tx_wr_en, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 2'b00);
    check("rst_rsp_bfd", rsp_bfd, 48'h0);
    reset_n = 1'b1;

    // A prompt byte while idle must be discarded.
    send_rx(8'h3E);

    // Addition, tx_sent held low briefly at the start.
    run_cmd(3'd0, "000012", "500000", 0, LINE_OK, 1'b1);
    check("add_tx_seq", tx_seq(tx_base), EXP_SEQ1);
    check("add_err", rsp_err, 2'b00);
    check("add_neg", rsp_neg, 1'b0);
    check("add_nan", rsp_nan, 1'b0);
    check("add_bfd", rsp_bfd, 48'h303030303132);
    check("add_afd", rsp_afd, 48'h353030303030);
    $display("[TB] add: err=%0d bfd=%h afd=%h", rsp_err, rsp_bfd, rsp_afd);

    // Cosine returning NaN.
    run_cmd(3'd5, "000001", "000000", 0, LINE_NAN, 1'b0);
    check("nan_op_char", tx_log[tx_base % 256], 8'h63);
    check("nan_flag", rsp_nan, 1'b1);
    check("nan_err", rsp_err, 2'b00);
    check("nan_bfd", rsp_bfd, 48'h303030303030);
    check("nan_afd", rsp_afd, 48'h303030303030);
    $display("[TB] nan: nan=%0d err=%0d", rsp_nan, rsp_err);

    // No echo for the first keystroke.
    run_cmd(3'd1, "000012", "500000", 1, LINE_OK, 1'b0);
    check("to_err", rsp_err, 2'b01);
    check("to_latency", rsp_cyc - wr_cyc, GAP + TMO);
    repeat (30) @(negedge clk);
    check("to_single_tx", tx_n - tx_base, 1);
    check("to_nan", rsp_nan, 1'b0);
    check("to_bfd", rsp_bfd, 48'h303030303030);
    $display("[TB] timeout: err=%0d latency=%0d", rsp_err, rsp_cyc - wr_cyc);

    // Corrupted echo of '1'.
    run_cmd(3'd0, "000012", "500000", 2, LINE_OK, 1'b0);
    check("echo_tx_count", tx_n - tx_base, 15);
    check("echo_tx_seq", tx_seq(tx_base), EXP_SEQ1);
    check("echo_err", rsp_err, ECHO_EXP_ERR);
    $display("[TB] bad echo: err=%0d", rsp_err);

    // Broken trailer.
    run_cmd(3'd2, "000012", "500000", 0, LINE_BADT, 1'b0);
    check("frame_op_char", tx_log[tx_base % 256], 8'h2A);
    check("frame_err", rsp_err, 2'b11);
    check("frame_nan", rsp_nan, 1'b0);
    check("frame_bfd", rsp_bfd, 48'h303030303030);
    $display("[TB] framing: err=%0d", rsp_err);

    // Negative result; op 7 goes out as '+'.
    run_cmd(3'd7, "000001", "000002", 0, LINE_NEG, 1'b0);
    check("neg_op_char", tx_log[tx_base % 256], 8'h2B);
    check("neg_flag", rsp_neg, 1'b1);
    check("neg_err", rsp_err, 2'b00);
    check("neg_bfd", rsp_bfd, 48'h303030303033);
    check("neg_afd", rsp_afd, 48'h303030303030);
    $display("[TB] negative: neg=%0d bfd=%h", rsp_neg, rsp_bfd);

    // Busy with cmd_valid held, then reset in the middle of collection.
    tx_base  = tx_n;
    rsp_base = rsp_n;
    fork
      responder(tx_base, 0, LINE_OK);
      begin
        @(negedge clk);
        cmd_op    = 3'd0;
        cmd_bfd   = "000012";
        cmd_afd   = "500000";
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_op = 3'd3;
        wait_tx(tx_base + 15, ok);
        check("busy_all_sent", ok, 1'b1);
        check("busy_not_ready", cmd_ready, 1'b0);
        check("busy_tx_seq", tx_seq(tx_base), EXP_SEQ1);
        repeat (GAP + 12) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_ready", cmd_ready, 1'b1);
        check("mid_rst_wr_en", tx_wr_en, 1'b0);
        check("mid_rst_valid", rsp_valid, 1'b0);
        check("mid_rst_bfd", rsp_bfd, 48'h0);
      end
    join
    check("mid_rst_no_rsp", rsp_n - rsp_base, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_ready", cmd_ready, 1'b1);
    @(negedge clk);
    check("accept_first_idle", cmd_ready, 1'b0);
    wait_tx(tx_base + 16, ok);
    check("accept_tx_seen", ok, 1'b1);
    check("accept_op_char", tx_log[(tx_base + 15) % 256], 8'h2F);
    $display("[TB] busy/reset: rsp=%0d first=%h", rsp_n - rsp_base, tx_log[(tx_base + 15) % 256]);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
